// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with a 2-flop input synchroniser, 3-sample
// majority voting per bit, and parity / framing / break reporting.
module uart_rx_cfg #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int BIT_RATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic                 VALID,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BREAK,
  output logic                 BUSY
);

  // CLK_PER_BIT must be at least 16 so the three vote samples sit well
  // inside the bit cell.
  localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW          = $clog2(CLK_PER_BIT) + 1;
  localparam int MID         = CLK_PER_BIT / 2;
  localparam int BW          = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_V0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_V1   = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } state_t;

  state_t                 state, state_d;
  logic                   sync1, rx_s, rx_q;
  logic [CW-1:0]          clk_cnt;
  logic                   vote0, vote1;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_bit;
  logic                   stop_idx;
  logic                   frame_err_acc;
  logic                   first_stop;

  logic decide, vote, stop0_now, is_break, par_err_now, frame_err_now;
  logic emit_valid, emit_break;

  // Input synchroniser plus one-cycle history for falling-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= RX;
      rx_s  <= sync1;
      rx_q  <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic, bit decision and end-of-frame event decode.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    emit_valid = 1'b0;
    emit_break = 1'b0;

    decide        = (clk_cnt == CNT_DEC);
    vote          = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);
    stop0_now     = (stop_idx == 1'b0) ? vote : first_stop;
    is_break      = (shift_reg == '0) && ((PARITY == 0) || !par_bit) && !stop0_now;
    frame_err_now = frame_err_acc | ~vote;

    par_err_now = 1'b0;
    if (PARITY == 1)      par_err_now = ~(^shift_reg ^ par_bit);
    else if (PARITY == 2) par_err_now =   ^shift_reg ^ par_bit;

    unique case (state)
      ST_IDLE: begin
        if (rx_q && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (decide) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide && bit_idx == IDX_LAST)
          state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (decide) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (decide && stop_idx == STOP_LAST) begin
          if (is_break) begin
            emit_break = 1'b1;
            state_d    = ST_BRK_WAIT;
          end else begin
            emit_valid = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit timer: free-runs over each bit cell while a frame is in progress and
  // sits at zero otherwise, so START always begins at count 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_cnt <= '0;
    end else if (state == ST_IDLE || state == ST_BRK_WAIT) begin
      clk_cnt <= '0;
    end else if (clk_cnt == CNT_LAST) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  // Vote samples, data shift register, parity bit and stop-bit bookkeeping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vote0         <= 1'b1;
      vote1         <= 1'b1;
      bit_idx       <= '0;
      shift_reg     <= '0;
      par_bit       <= 1'b0;
      stop_idx      <= 1'b0;
      frame_err_acc <= 1'b0;
      first_stop    <= 1'b1;
    end else begin
      if (clk_cnt == CNT_V0) vote0 <= rx_s;
      if (clk_cnt == CNT_V1) vote1 <= rx_s;

      if (state == ST_START)
        bit_idx <= '0;
      else if (state == ST_DATA && decide)
        bit_idx <= bit_idx + BW'(1);

      // LSB arrives first, so shift right and insert at the top.
      if (state == ST_DATA && decide)
        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};

      if (state == ST_PARITY && decide)
        par_bit <= vote;

      if (state != ST_STOP) begin
        stop_idx      <= 1'b0;
        frame_err_acc <= 1'b0;
      end else if (decide) begin
        stop_idx <= stop_idx + 1'b1;
        if (!vote)             frame_err_acc <= 1'b1;
        if (stop_idx == 1'b0)  first_stop    <= vote;
      end
    end
  end

  // Registered outputs: one-cycle event pulses, result held until next VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALID      <= 1'b0;
      BREAK      <= 1'b0;
      DATA       <= '0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      VALID <= emit_valid;
      BREAK <= emit_break;
      if (emit_valid) begin
        DATA       <= shift_reg;
        PARITY_ERR <= par_err_now;
        FRAME_ERR  <= frame_err_now;
      end
    end
  end

  assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed, table-driven bench for uart_rx_cfg. Three
// instances cover 8N1 at the default rate, 8E1 and 7N2 at a fast rate.
module tb_uart_rx_cfg;

  localparam int NI = 3;
  localparam int CPB   [NI] = '{1250, 32, 32};
  localparam int DBITS [NI] = '{8, 8, 7};
  localparam int PBIT  [NI] = '{0, 1, 0};
  localparam int SBITS [NI] = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx    [NI];
  logic       valid [NI];
  logic       perr  [NI];
  logic       ferr  [NI];
  logic       brk   [NI];
  logic       busy  [NI];
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [8:0] data9 [NI];

  always #5 clk = ~clk;

  always_comb begin
    data9[0] = {1'b0, data_a};
    data9[1] = {1'b0, data_b};
    data9[2] = {2'b00, data_c};
  end

  uart_rx_cfg u_a (
    .CLK(clk), .RST_N(rst_n), .RX(rx[0]), .VALID(valid[0]), .DATA(data_a),
    .PARITY_ERR(perr[0]), .FRAME_ERR(ferr[0]), .BREAK(brk[0]), .BUSY(busy[0])
  );

  uart_rx_cfg #(.CLK_HZ(12_000_000), .BIT_RATE(375_000), .PARITY(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .RX(rx[1]), .VALID(valid[1]), .DATA(data_b),
    .PARITY_ERR(perr[1]), .FRAME_ERR(ferr[1]), .BREAK(brk[1]), .BUSY(busy[1])
  );

  uart_rx_cfg #(.CLK_HZ(12_000_000), .BIT_RATE(375_000), .DATA_BITS(7),
                .STOP_BITS(2)) u_c (
    .CLK(clk), .RST_N(rst_n), .RX(rx[2]), .VALID(valid[2]), .DATA(data_c),
    .PARITY_ERR(perr[2]), .FRAME_ERR(ferr[2]), .BREAK(brk[2]), .BUSY(busy[2])
  );

  // Event monitor: counts pulses and captures results on the falling edge.
  int         cyc;
  int         valid_cnt [NI];
  int         brk_cnt   [NI];
  int         valid_cyc [NI];
  int         start_cyc [NI];
  int         both_cnt;
  logic [8:0] cap_data  [NI];
  logic       cap_perr  [NI];
  logic       cap_ferr  [NI];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (valid[i]) begin
        valid_cnt[i] <= valid_cnt[i] + 1;
        valid_cyc[i] <= cyc;
        cap_data[i]  <= data9[i];
        cap_perr[i]  <= perr[i];
        cap_ferr[i]  <= ferr[i];
      end
      if (brk[i]) brk_cnt[i] <= brk_cnt[i] + 1;
      if (valid[i] && brk[i]) both_cnt <= both_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full frame on instance i; stop0 is the first stop bit, later ones are 1.
  task automatic send_frame(input int i, input logic [8:0] d, input logic par,
                            input logic stop0);
    rx[i] = 1'b0;
    start_cyc[i] = cyc;
    wait_cyc(CPB[i]);
    for (int b = 0; b < DBITS[i]; b++) begin
      rx[i] = d[b];
      wait_cyc(CPB[i]);
    end
    if (PBIT[i] != 0) begin
      rx[i] = par;
      wait_cyc(CPB[i]);
    end
    for (int s = 0; s < SBITS[i]; s++) begin
      rx[i] = (s == 0) ? stop0 : 1'b1;
      wait_cyc(CPB[i]);
    end
    rx[i] = 1'b1;
  endtask

  // Start edge to VALID should be (DATA_BITS+P+STOP_BITS+0.5)*CPB + ~4.
  task automatic check_lat(input string name, input int i);
    int exp_lat;
    int act;
    exp_lat = (DBITS[i] + PBIT[i] + SBITS[i]) * CPB[i] + CPB[i] / 2 + 4;
    act     = valid_cyc[i] - start_cyc[i];
    checks++;
    if (act < exp_lat - 1 || act > exp_lat + 2) begin
      errors++;
      $display("FAIL %s: latency %0d cycles, expected %0d (-1/+2)", name, act, exp_lat);
    end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par;
    logic       stop0;
    int         exp_valid;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int b0;

    // inst, data, parity bit, first stop, valid, data, perr, ferr
    vecs[0] = '{0, 9'h055, 1'b0, 1'b1, 1, 9'h055, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h03C, 1'b0, 1'b0, 1, 9'h03C, 1'b0, 1'b1};
    vecs[2] = '{1, 9'h0A5, 1'b0, 1'b1, 1, 9'h0A5, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h0A5, 1'b1, 1'b1, 1, 9'h0A5, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h000, 1'b0, 1'b1, 1, 9'h000, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h080, 1'b1, 1'b0, 1, 9'h080, 1'b0, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) rx[i] = 1'b1;
    wait_cyc(5);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_valid", i), valid[i], 0);
      check($sformatf("rst%0d_break", i), brk[i], 0);
      check($sformatf("rst%0d_data", i), data9[i], 0);
      check($sformatf("rst%0d_perr", i), perr[i], 0);
      check($sformatf("rst%0d_ferr", i), ferr[i], 0);
      check($sformatf("rst%0d_busy", i), busy[i], 0);
    end
    rst_n = 1'b1;
    wait_cyc(5);

    for (int k = 0; k < NV; k++) begin
      int n;
      n  = vecs[k].inst;
      v0 = valid_cnt[n];
      b0 = brk_cnt[n];
      send_frame(n, vecs[k].data, vecs[k].par, vecs[k].stop0);
      wait_cyc(2 * CPB[n]);
      check($sformatf("v%0d_valid_cnt", k), valid_cnt[n] - v0, vecs[k].exp_valid);
      check($sformatf("v%0d_break_cnt", k), brk_cnt[n] - b0, 0);
      check($sformatf("v%0d_data", k), cap_data[n], vecs[k].exp_data);
      check($sformatf("v%0d_perr", k), cap_perr[n], vecs[k].exp_perr);
      check($sformatf("v%0d_ferr", k), cap_ferr[n], vecs[k].exp_ferr);
      check($sformatf("v%0d_busy_after", k), busy[n], 0);
      check_lat($sformatf("v%0d_latency", k), n);
    end

    // Short low glitch on an idle line: rejected at the start-bit vote.
    v0 = valid_cnt[0];
    b0 = brk_cnt[0];
    rx[0] = 1'b0;
    wait_cyc(200);
    check("glitch_busy_during", busy[0], 1);
    wait_cyc(100);
    rx[0] = 1'b1;
    wait_cyc(2 * CPB[0]);
    check("glitch_valid_cnt", valid_cnt[0] - v0, 0);
    check("glitch_break_cnt", brk_cnt[0] - b0, 0);
    check("glitch_busy_after", busy[0], 0);

    // Line held low for 20 bit times: one BREAK, DATA keeps the last word.
    v0 = valid_cnt[1];
    b0 = brk_cnt[1];
    rx[1] = 1'b0;
    wait_cyc(20 * CPB[1]);
    check("break_busy_low_line", busy[1], 1);
    check("break_pulse_cnt", brk_cnt[1] - b0, 1);
    check("break_valid_cnt", valid_cnt[1] - v0, 0);
    check("break_data_hold", data9[1], 9'h080);
    rx[1] = 1'b1;
    wait_cyc(5);
    check("break_busy_released", busy[1], 0);
    send_frame(1, 9'h012, 1'b0, 1'b1);
    wait_cyc(2 * CPB[1]);
    check("post_break_valid_cnt", valid_cnt[1] - v0, 1);
    check("post_break_data", cap_data[1], 9'h012);
    check("post_break_perr", cap_perr[1], 0);
    check("post_break_ferr", cap_ferr[1], 0);
    check("post_break_break_cnt", brk_cnt[1] - b0, 1);

    // 7N2 back-to-back frames: the second start edge follows the last stop bit.
    v0 = valid_cnt[2];
    send_frame(2, 9'h041, 1'b0, 1'b1);
    check("b2b_first_valid_cnt", valid_cnt[2] - v0, 1);
    check("b2b_first_data", cap_data[2], 9'h041);
    send_frame(2, 9'h07F, 1'b0, 1'b1);
    wait_cyc(2 * CPB[2]);
    check("b2b_second_valid_cnt", valid_cnt[2] - v0, 2);
    check("b2b_second_data", cap_data[2], 9'h07F);
    check("b2b_second_ferr", cap_ferr[2], 0);
    check_lat("b2b_second_latency", 2);

    // Reset in the middle of a third frame: outputs clear, no VALID follows.
    v0 = valid_cnt[2];
    b0 = brk_cnt[2];
    rx[2] = 1'b0;
    wait_cyc(CPB[2]);
    rx[2] = 1'b1;
    wait_cyc(CPB[2]);
    rx[2] = 1'b0;
    wait_cyc(CPB[2] + 10);
    check("midrst_busy_before", busy[2], 1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midrst_valid", valid[2], 0);
    check("midrst_break", brk[2], 0);
    check("midrst_data", data9[2], 0);
    check("midrst_perr", perr[2], 0);
    check("midrst_ferr", ferr[2], 0);
    check("midrst_busy", busy[2], 0);
    rx[2] = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(15 * CPB[2]);
    check("midrst_valid_cnt", valid_cnt[2] - v0, 0);
    check("midrst_break_cnt", brk_cnt[2] - b0, 0);
    check("midrst_busy_after", busy[2], 0);

    check("valid_break_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised successor to the team's fixed 8N1 UART receiver.
- Configurable data width, parity mode and stop-bit count, with a synchronised RX input and 3-sample majority voting.
- Reports parity error, framing error and break condition.
- Sits between a PMOD/pin RX line and byte-consuming logic on the iCESugar-nano.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- BIT_RATE, 9600, line bit rate in bits/s; CLK_PER_BIT = CLK_HZ/BIT_RATE, must be >= 16.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST_N  input  1  asynchronous active-low reset.
- RX  input  1  asynchronous serial line, idle high.
- VALID  output  1  one-cycle pulse: frame complete, DATA/PARITY_ERR/FRAME_ERR valid.
- DATA  output  DATA_BITS  received word, LSB = first bit on line.
- PARITY_ERR  output  1  qualified by VALID; always 0 when PARITY = 0.
- FRAME_ERR  output  1  qualified by VALID; a sampled stop bit was 0.
- BREAK  output  1  one-cycle pulse on break detection.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, RST_N low):
  - State = IDLE; all counters = 0.
  - Both synchroniser flops and the edge register = 1.
  - VALID = 0, BREAK = 0, PARITY_ERR = 0, FRAME_ERR = 0, DATA = 0.
  - Reset mid-frame aborts the frame and emits no VALID.
- Input path:
  - RX passes through a 2-flop synchroniser to rx_s; rx_q holds the previous rx_s.
  - All decisions use rx_s, so there are 2 cycles of input latency.
- Bit timer:
  - clk_cnt, width $clog2(CLK_PER_BIT)+1, counts 0..CLK_PER_BIT-1 then wraps to 0.
  - Cleared on entry to START.
- Sampling:
  - Majority vote of rx_s at counts M-1, M and M+1, where M = CLK_PER_BIT/2.
  - The bit decision is registered at count M+1.
- States:
  - IDLE: falling edge (rx_q = 1, rx_s = 0) -> START. A line held low without a prior high does not start a frame.
  - START: at the decision point, majority 1 -> IDLE (glitch, no output); majority 0 -> DATA with bit index 0.
  - DATA: one decision per bit period, shifted in LSB-first. After bit DATA_BITS-1 -> PARITY if PARITY != 0, else STOP.
  - PARITY: parity bit sampled. Odd mode requires XOR(data, parity) = 1; even mode requires 0.
  - STOP: STOP_BITS decisions taken. Any 0 sets the frame error. After the last stop decision, the output event follows the rules below and the FSM returns to IDLE in the next cycle.
  - BRK_WAIT: stays until rx_s = 1, then -> IDLE.
- Output event (at the last stop decision):
  - Normal frame: DATA, PARITY_ERR and FRAME_ERR update and VALID pulses in the cycle after the last stop-bit decision.
  - Break: data all 0, parity bit (if present) 0 and the first stop bit 0. BREAK pulses, VALID stays 0, DATA holds its old value, and the FSM goes to BRK_WAIT instead of IDLE.
  - A framing error on non-zero data asserts VALID together with FRAME_ERR = 1.
  - VALID and BREAK are never high together.
- Output timing:
  - Total latency from the RX start edge to VALID ≈ (1 + DATA_BITS + P + STOP_BITS - 0.5) × CLK_PER_BIT + 4 cycles, where P = 1 if parity is enabled, else 0.
  - DATA holds its value until the next VALID.
  - Back-to-back frames: since IDLE is re-entered at the middle of the stop bit, a start edge arriving immediately after the stop bit is accepted.

Test Plan:
- Defaults (CLK_PER_BIT = 1250), send 0x55 8N1 -> one VALID pulse, DATA = 0x55, both error flags 0, BUSY low afterwards.
- PARITY = 2: send 0xA5 with parity bit 0 -> VALID, PARITY_ERR = 0. Resend with parity bit 1 -> VALID, PARITY_ERR = 1, DATA = 0xA5.
- Send 0x3C with stop bit 0, then line high -> VALID, FRAME_ERR = 1, DATA = 0x3C.
- Hold RX low for 20 bit times -> one BREAK pulse, no VALID, BUSY high until RX returns high. A following frame 0x12 is received correctly.
- 300-cycle low glitch on idle line -> no VALID, no BREAK, FSM back in IDLE.
- DATA_BITS = 7, STOP_BITS = 2: two back-to-back frames 0x41, 0x7F -> two VALID pulses with the correct data. Assert RST_N low mid-way through a third frame -> all outputs 0, no VALID.
